// File: rtl/arbitro_mux.sv
// Four-requester burst arbiter with a data mux toward a single downstream port.
// Define ARBITRO_MUX_RR_EN for round-robin arbitration; the default build uses fixed priority.
module arbitro_mux #(
  parameter int MAX_RAFAGA = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Req,
  input  logic [3:0] i_Datos_0,
  input  logic [3:0] i_Datos_1,
  input  logic [3:0] i_Datos_2,
  input  logic [3:0] i_Datos_3,
  input  logic       i_Ack,
  output logic [3:0] o_Gnt,
  output logic [1:0] o_Sel,
  output logic [3:0] o_Salida,
  output logic       o_Valido
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [3:0] MAX_BEATS = 4'(MAX_RAFAGA);

  state_t     state, state_next;
  logic [3:0] gnt, gnt_next;
  logic [1:0] sel, sel_next;
  logic [3:0] cnt, cnt_next;
  logic [1:0] winner;
  logic       valid;
  logic       beat;

`ifdef ARBITRO_MUX_RR_EN
  logic [1:0] ptr, ptr_next;

  // Scan from the highest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    winner = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (i_Req[ptr + 2'(k)]) winner = ptr + 2'(k);
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (state == IDLE && i_Req != 4'b0000) ptr_next = winner + 2'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) ptr <= 2'd0;
    else       ptr <= ptr_next;
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (i_Req[k]) winner = 2'(k);
    end
  end
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      sel   <= sel_next;
      cnt   <= cnt_next;
    end
  end

  assign beat = valid & i_Ack;

  // Leaving XFER always clears the grant, which guarantees one idle cycle before the next one.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    sel_next   = sel;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        gnt_next = 4'b0000;
        if (i_Req != 4'b0000) begin
          state_next = XFER;
          gnt_next   = 4'b0001 << winner;
          sel_next   = winner;
          cnt_next   = 4'd0;
        end
      end
      XFER: begin
        if (!i_Req[sel]) begin
          state_next = IDLE;
          gnt_next   = 4'b0000;
          cnt_next   = 4'd0;
        end else if (beat) begin
          if (cnt + 4'd1 == MAX_BEATS) begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    valid = (state == XFER) && i_Req[sel];
    case (sel)
      2'd0:    o_Salida = i_Datos_0;
      2'd1:    o_Salida = i_Datos_1;
      2'd2:    o_Salida = i_Datos_2;
      default: o_Salida = i_Datos_3;
    endcase
    o_Gnt    = gnt;
    o_Sel    = sel;
    o_Valido = valid;
  end

endmodule

// File: tb/tb_arbitro_mux.sv
// Directed self-checking bench for arbitro_mux; a second instance with MAX_RAFAGA=1
// shares the inputs and is only checked in the single-beat scenario.
module tb_arbitro_mux;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [3:0] i_Req;
  logic [3:0] i_Datos_0, i_Datos_1, i_Datos_2, i_Datos_3;
  logic       i_Ack;
  logic [3:0] o_Gnt, o_Salida;
  logic [1:0] o_Sel;
  logic       o_Valido;
  logic [3:0] gnt1, salida1;
  logic [1:0] sel1;
  logic       valido1;

  int numCompared   = 0;
  int numMismatched = 0;
  logic [3:0] expGnt;

  arbitro_mux #(.MAX_RAFAGA(4)) u_dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req),
    .i_Datos_0(i_Datos_0), .i_Datos_1(i_Datos_1), .i_Datos_2(i_Datos_2), .i_Datos_3(i_Datos_3),
    .i_Ack(i_Ack), .o_Gnt(o_Gnt), .o_Sel(o_Sel), .o_Salida(o_Salida), .o_Valido(o_Valido)
  );

  arbitro_mux #(.MAX_RAFAGA(1)) u_dut1 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req),
    .i_Datos_0(i_Datos_0), .i_Datos_1(i_Datos_1), .i_Datos_2(i_Datos_2), .i_Datos_3(i_Datos_3),
    .i_Ack(i_Ack), .o_Gnt(gnt1), .o_Sel(sel1), .o_Salida(salida1), .o_Valido(valido1)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic ack);
    i_Rst = rst;
    i_Req = req;
    i_Ack = ack;
  endtask

  // Advance n rising edges; inputs are changed 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    i_Datos_0 = 4'b0101;
    i_Datos_1 = 4'b0011;
    i_Datos_2 = 4'b1010;
    i_Datos_3 = 4'b1100;
    applyStimulus(1'b1, 4'b0000, 1'b0);
    cyc(2);

    // Reset state
    @(negedge i_Clk);
    checkOutput("rst_gnt", o_Gnt, 4'b0000);
    checkOutput("rst_sel", o_Sel, 2'd0);
    checkOutput("rst_valido", o_Valido, 1'b0);
    checkOutput("rst_salida", o_Salida, 4'b0101);

    // Single requester 2, four accepted beats
    cyc(1);
    applyStimulus(1'b0, 4'b0100, 1'b1);
    @(negedge i_Clk);
    checkOutput("t1_pre_gnt", o_Gnt, 4'b0000);
    cyc(1);
    @(negedge i_Clk);
    checkOutput("t1_gnt", o_Gnt, 4'b0100);
    checkOutput("t1_sel", o_Sel, 2'd2);
    checkOutput("t1_valido", o_Valido, 1'b1);
    checkOutput("t1_salida", o_Salida, 4'b1010);
    cyc(3);
    @(negedge i_Clk);
    checkOutput("t1_beat3_gnt", o_Gnt, 4'b0100);
    cyc(1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    @(negedge i_Clk);
    checkOutput("t1_end_gnt", o_Gnt, 4'b0000);
    checkOutput("t1_end_valido", o_Valido, 1'b0);
    checkOutput("t1_idle_sel", o_Sel, 2'd2);
    cyc(1);

    // Requester 0 stalled by i_Ack low for five cycles
    applyStimulus(1'b0, 4'b0001, 1'b0);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_Clk);
      checkOutput("t2_stall_gnt", o_Gnt, 4'b0001);
      cyc(1);
    end
    applyStimulus(1'b0, 4'b0001, 1'b1);
    cyc(3);
    @(negedge i_Clk);
    checkOutput("t2_beat3_gnt", o_Gnt, 4'b0001);
    cyc(1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    @(negedge i_Clk);
    checkOutput("t2_end_gnt", o_Gnt, 4'b0000);
    cyc(1);

    // Requester 1 drops its request after two beats
    applyStimulus(1'b0, 4'b0010, 1'b1);
    cyc(1);
    @(negedge i_Clk);
    checkOutput("t3_gnt", o_Gnt, 4'b0010);
    checkOutput("t3_salida", o_Salida, 4'b0011);
    cyc(2);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    @(negedge i_Clk);
    checkOutput("t3_drop_valido", o_Valido, 1'b0);
    checkOutput("t3_drop_gnt", o_Gnt, 4'b0010);
    cyc(1);
    @(negedge i_Clk);
    checkOutput("t3_idle_gnt", o_Gnt, 4'b0000);
    cyc(1);
    @(negedge i_Clk);
    checkOutput("t3_ack_ignored_gnt", o_Gnt, 4'b0000);

    // Reset in the middle of a burst
    applyStimulus(1'b0, 4'b0100, 1'b1);
    cyc(1);
    @(negedge i_Clk);
    checkOutput("t4_gnt", o_Gnt, 4'b0100);
    cyc(2);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    cyc(1);
    @(negedge i_Clk);
    checkOutput("t4_rst_gnt", o_Gnt, 4'b0000);
    checkOutput("t4_rst_sel", o_Sel, 2'd0);
    checkOutput("t4_rst_valido", o_Valido, 1'b0);
    checkOutput("t4_rst_salida", o_Salida, 4'b0101);
    cyc(1);
    @(negedge i_Clk);
    checkOutput("t4_rst_hold_gnt", o_Gnt, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    cyc(1);

    // All four requesting: order depends on arbitration mode
    applyStimulus(1'b0, 4'b1111, 1'b1);
    for (int g = 0; g < 5; g++) begin
`ifdef ARBITRO_MUX_RR_EN
      expGnt = 4'b0001 << (g % 4);
`else
      expGnt = 4'b0001;
`endif
      cyc(1);
      @(negedge i_Clk);
      checkOutput("t5_gnt", o_Gnt, expGnt);
      cyc(3);
      @(negedge i_Clk);
      checkOutput("t5_hold_gnt", o_Gnt, expGnt);
      cyc(1);
      @(negedge i_Clk);
      checkOutput("t5_gap_gnt", o_Gnt, 4'b0000);
    end

    // Single-beat bursts on the MAX_RAFAGA=1 instance
    applyStimulus(1'b1, 4'b0000, 1'b1);
    cyc(1);
    applyStimulus(1'b0, 4'b0011, 1'b1);
    for (int g = 0; g < 4; g++) begin
`ifdef ARBITRO_MUX_RR_EN
      expGnt = 4'b0001 << (g % 2);
`else
      expGnt = 4'b0001;
`endif
      cyc(1);
      @(negedge i_Clk);
      checkOutput("t6_gnt", gnt1, expGnt);
      checkOutput("t6_valido", valido1, 1'b1);
      cyc(1);
      @(negedge i_Clk);
      checkOutput("t6_gap_gnt", gnt1, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/arbitro_mux.md
ARBITRO_MUX -- requirements
Module: arbitro_mux

Interface
REQ-001 SHALL have parameter: MAX_RAFAGA, default 4, max accepted beats per grant (legal 1..8).
REQ-002 SHALL have port: i_Clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port: i_Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: i_Req  input  4  request per requester n (bit n).
REQ-005 SHALL have ports: i_Datos_0..i_Datos_3  input  4 each  data of requester 0..3, held stable while its i_Req is high.
REQ-006 SHALL have port: i_Ack  input  1  downstream accepts the current beat.
REQ-007 SHALL have port: o_Gnt  output  4  one-hot grant, or 0000 when no grant.
REQ-008 SHALL have port: o_Sel  output  2  index of granted requester (mux select).
REQ-009 SHALL have port: o_Salida  output  4  data of the requester indexed by o_Sel.
REQ-010 SHALL have port: o_Valido  output  1  beat valid toward downstream.

Function
REQ-011 SHALL implement FSM with states IDLE and XFER only.
REQ-012 SHALL, in IDLE with i_Req != 0, select a winner per REQ-019/REQ-020, register o_Gnt/o_Sel at that edge, clear beat counter, enter XFER; grant latency exactly 1 cycle from first sampled request.
REQ-013 SHALL, in IDLE with i_Req == 0, remain in IDLE with o_Gnt = 0000.
REQ-014 SHALL drive o_Salida = i_Datos_[o_Sel] combinationally in all states; o_Sel holds last value in IDLE.
REQ-015 SHALL drive o_Valido = (state == XFER) AND i_Req[o_Sel]; o_Valido is 0 in IDLE.
REQ-016 SHALL count a beat only when o_Valido AND i_Ack are both high at a rising edge.
REQ-017 SHALL leave XFER for IDLE (o_Gnt -> 0000 next cycle) when i_Req[o_Sel] is sampled low, or when the beat completing at that edge is beat number MAX_RAFAGA.
REQ-018 SHALL keep o_Gnt/o_Sel constant throughout XFER; requests from other requesters during XFER have no effect until IDLE.
REQ-019 SHALL (with ARBITRO_MUX_RR_EN) choose the first requesting index at or after a 2-bit round-robin pointer, wrapping 3 -> 0, and set pointer = winner + 1 (mod 4) on grant.
REQ-020 SHALL (without ARBITRO_MUX_RR_EN) choose the lowest requesting index (0 highest priority); no pointer state.
REQ-021 SHALL insert exactly one IDLE cycle between consecutive grants (no back-to-back grant).
REQ-022 SHALL, when i_Ack is high while o_Valido is low, ignore it (no count, no state change).
REQ-023 SHALL size the beat counter at 4 bits; counter never exceeds MAX_RAFAGA.

Reset
REQ-024 SHALL, when i_Rst is high at a rising edge, force state IDLE, o_Gnt = 0000, o_Sel = 00, beat counter = 0, pointer = 0, regardless of state or inputs (including mid-XFER).
REQ-025 SHALL produce o_Valido = 0 and o_Salida = i_Datos_0 in the cycle after reset.
REQ-026 SHALL not grant in any cycle where i_Rst is sampled high.

Configuration
REQ-027 SHALL compile round-robin arbitration (REQ-019) only when macro ARBITRO_MUX_RR_EN is defined.
REQ-028 SHALL compile fixed priority (REQ-020) when ARBITRO_MUX_RR_EN is undefined; all ports and timing otherwise identical.

Verification
REQ-029 SHALL cover: reset, then i_Req=0100, i_Datos_2=1010, i_Ack=1 -> next cycle o_Gnt=0100, o_Sel=10, o_Valido=1, o_Salida=1010; 4 beats then o_Gnt=0000.
REQ-030 SHALL cover: i_Req=0001 held, i_Ack=0 for 5 cycles then 1 -> grant kept, no beats counted while i_Ack=0, release after 4th accepted beat.
REQ-031 SHALL cover: i_Req=1111 constant, i_Ack=1, RR_EN defined -> grant order 0,1,2,3,0 each 4 beats separated by one IDLE cycle; undefined -> always 0.
REQ-032 SHALL cover: granted requester 1 drops i_Req after 2 beats -> o_Valido=0 that cycle, IDLE next, counter 0.
REQ-033 SHALL cover: i_Rst=1 mid-XFER at beat 2 -> next cycle o_Gnt=0000, o_Sel=00, o_Valido=0, pointer 0.
REQ-034 SHALL cover: MAX_RAFAGA=1, i_Req=0011, RR_EN defined -> grants alternate 0,1,0,1, one beat each.
